// File: rtl/player_pkg.sv
// Shared encodings for the player-heart controller: game-state codes, heart FSM states, coordinate width.
package player_pkg;
    localparam int COORD_W = 10;

    localparam logic [1:0] ST_MENU = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;

    typedef enum logic [1:0] {
        ALIVE = 2'd0,
        HIT   = 2'd1,
        DEAD  = 2'd2
    } heart_st_e;
endpackage

// File: rtl/axis_step.sv
// One axis of heart motion: optional +/-STEP, then clamp into [lo, hi-size+1]. Purely combinational.
module axis_step
    import player_pkg::*;
#(
    parameter int STEP = 5
) (
    input  logic [COORD_W-1:0] pos,
    input  logic               dec,
    input  logic               inc,
    input  logic [COORD_W-1:0] lo,
    input  logic [COORD_W-1:0] hi,
    input  logic [COORD_W-1:0] size,
    output logic [COORD_W-1:0] next_pos
);
    localparam logic signed [11:0] STEP_S = 12'(STEP);

    logic signed [11:0] cand;
    logic signed [11:0] lo_s;
    logic signed [11:0] hi_s;
    logic signed [11:0] res;

    always_comb begin
        cand = $signed({2'b00, pos});
        if (dec && !inc) begin
            cand = cand - STEP_S;
        end else if (inc && !dec) begin
            cand = cand + STEP_S;
        end
        lo_s = $signed({2'b00, lo});
        hi_s = $signed({2'b00, hi}) - $signed({2'b00, size}) + 12'sd1;
        // Lower bound applied last so a degenerate box still pins the heart at lo.
        res = (cand > hi_s) ? hi_s : cand;
        res = (res < lo_s) ? lo_s : res;
    end

    assign next_pos = COORD_W'(res);
endmodule

// File: rtl/player_heart_ctrl.sv
// Player heart: clamped frame-paced motion, hit/i-frame/death FSM, sprite ROM addressing.
// rom_addr valid 1 cycle after x/y; sprite_on delayed 2 cycles to line up with ROM data.
module player_heart_ctrl
    import player_pkg::*;
#(
    parameter int SPR_W     = 31,
    parameter int SPR_H     = 27,
    parameter int START_X   = 305,
    parameter int START_Y   = 227,
    parameter int STEP      = 5,
    parameter int HP_MAX    = 3,
    parameter int HP_W      = 2,
    parameter int IFRAMES   = 60,
    parameter int BLINK_BIT = 2,
    parameter int ADDR_W    = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         state,
    input  logic [3:0]         btn,
    input  logic               frame_tick,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic               collision,
    input  logic [9:0]         left_b,
    input  logic [9:0]         right_b,
    input  logic [9:0]         top_b,
    input  logic [9:0]         bottom_b,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic               sprite_on,
    output logic [HP_W-1:0]    hp,
    output logic               invuln,
    output logic               dead,
    output logic [9:0]         pos_x,
    output logic [9:0]         pos_y
);
    localparam int CNT_W = ($clog2(IFRAMES + 1) > BLINK_BIT) ? $clog2(IFRAMES + 1) : BLINK_BIT + 1;

    logic [COORD_W-1:0] pos_x_q, pos_y_q, pos_x_d, pos_y_d;
    logic               play_q;
    heart_st_e          fsm_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [HP_W-1:0]    hp_q, hp_dec;
    logic               invuln_q, dead_q;
    logic [ADDR_W-1:0]  rom_addr_q, addr_d;
    logic               vis_q, sprite_on_q;
    logic               in_play, entry, move_en, in_box, vis_d;
    logic [COORD_W-1:0] dx, dy;

    assign in_play = (state == ST_PLAY);
    assign entry   = in_play && !play_q;
    assign move_en = frame_tick && in_play && (fsm_q != DEAD);

    // btn = {up, down, left, right}
    axis_step #(.STEP(STEP)) u_axis_x (
        .pos(pos_x_q), .dec(btn[1]), .inc(btn[0]),
        .lo(left_b), .hi(right_b), .size(COORD_W'(SPR_W)), .next_pos(pos_x_d)
    );
    axis_step #(.STEP(STEP)) u_axis_y (
        .pos(pos_y_q), .dec(btn[3]), .inc(btn[2]),
        .lo(top_b), .hi(bottom_b), .size(COORD_W'(SPR_H)), .next_pos(pos_y_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_x_q <= COORD_W'(START_X);
            pos_y_q <= COORD_W'(START_Y);
            play_q  <= 1'b0;
        end else begin
            play_q <= in_play;
            if (entry) begin
                pos_x_q <= COORD_W'(START_X);
                pos_y_q <= COORD_W'(START_Y);
            end else if (move_en) begin
                pos_x_q <= pos_x_d;
                pos_y_q <= pos_y_d;
            end
        end
    end

    assign hp_dec = (hp_q == '0) ? '0 : hp_q - HP_W'(1);

    always_ff @(posedge clk) begin
        if (reset || state == ST_MENU) begin
            fsm_q    <= ALIVE;
            hp_q     <= HP_W'(HP_MAX);
            cnt_q    <= '0;
            invuln_q <= 1'b0;
            dead_q   <= 1'b0;
        end else begin
            case (fsm_q)
                ALIVE: begin
                    if (collision && in_play) begin
                        hp_q <= hp_dec;
                        if (hp_dec == '0) begin
                            fsm_q  <= DEAD;
                            cnt_q  <= '0;
                            dead_q <= 1'b1;
                        end else begin
                            fsm_q    <= HIT;
                            cnt_q    <= CNT_W'(IFRAMES);
                            invuln_q <= 1'b1;
                        end
                    end
                end
                HIT: begin
                    if (frame_tick) begin
                        if (cnt_q <= CNT_W'(1)) begin
                            cnt_q    <= '0;
                            fsm_q    <= ALIVE;
                            invuln_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                end
                DEAD: begin
                    dead_q <= 1'b1;
                end
                default: begin
                    fsm_q <= ALIVE;
                end
            endcase
        end
    end

    assign in_box = ({1'b0, x} >= {1'b0, pos_x_q}) && ({1'b0, x} < {1'b0, pos_x_q} + 11'(SPR_W))
                 && ({1'b0, y} >= {1'b0, pos_y_q}) && ({1'b0, y} < {1'b0, pos_y_q} + 11'(SPR_H));
    assign dx     = x - pos_x_q;
    assign dy     = y - pos_y_q;
    assign addr_d = ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx);
    assign vis_d  = in_box && in_play && !(invuln_q && cnt_q[BLINK_BIT]);

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr_q  <= '0;
            vis_q       <= 1'b0;
            sprite_on_q <= 1'b0;
        end else begin
            if (in_box) begin
                rom_addr_q <= addr_d;
            end
            vis_q       <= vis_d;
            sprite_on_q <= vis_q;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign sprite_on = sprite_on_q;
    assign hp        = hp_q;
    assign invuln    = invuln_q;
    assign dead      = dead_q;
    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
endmodule
